// File: rtl/fifo_serializer.sv
// Pops one packet at a time from an upstream FIFO and streams it LSB-flit-first
// over a valid/ready link, counting completed packets.
module fifo_serializer #(
  parameter int DATA_LINE_WIDTH = 40,
  parameter int FLIT_WIDTH      = 8,
  parameter int NUM_FLITS       = 5,
  parameter int LOG2_NUM_FLITS  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_empty_flag,
  output logic                       o_read_packet_en,
  input  logic [DATA_LINE_WIDTH-1:0] i_read_packet,
  output logic [FLIT_WIDTH-1:0]      o_flit,
  output logic                       o_flit_valid,
  output logic                       o_flit_last,
  input  logic                       i_flit_ready,
  output logic                       o_busy,
  output logic [15:0]                o_pkt_count
);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                      state, state_nxt;
  logic [LOG2_NUM_FLITS-1:0]   cnt;
  logic [DATA_LINE_WIDTH-1:0]  shreg;
  logic [15:0]                 pkt_count_q;
  logic                        accept, last_flit, read_en;

  assign last_flit = (state == SEND) && (cnt == LOG2_NUM_FLITS'(NUM_FLITS - 1));
  assign accept    = (state == SEND) && i_flit_ready;

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    case (state)
      IDLE: if (!i_empty_flag) begin
        read_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = SEND;
      SEND: if (accept && last_flit) begin
        // Pop the next packet in the same cycle the last flit leaves.
        if (!i_empty_flag) begin
          read_en   = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      shreg       <= '0;
      pkt_count_q <= '0;
    end else begin
      if (state == WAIT) begin
        shreg <= i_read_packet;
        cnt   <= '0;
      end else if (accept) begin
        shreg <= shreg >> FLIT_WIDTH;
        cnt   <= cnt + 1'b1;
        if (last_flit) pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  assign o_read_packet_en = read_en && !rst;
  assign o_flit_valid     = (state == SEND);
  assign o_flit           = (state == SEND) ? shreg[FLIT_WIDTH-1:0] : '0;
  assign o_flit_last      = last_flit;
  assign o_busy           = (state != IDLE);
  assign o_pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Randomized bench for fifo_serializer: a queue-based FIFO plus a flit-level
// scoreboard predict every flit, pop, busy flag and packet count.
module tb_fifo_serializer;
  localparam int DW = 40;
  localparam int FW = 8;
  localparam int NF = 5;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_empty_flag = 1'b1;
  logic          o_read_packet_en;
  logic [DW-1:0] i_read_packet = '0;
  logic [FW-1:0] o_flit;
  logic          o_flit_valid;
  logic          o_flit_last;
  logic          i_flit_ready = 1'b0;
  logic          o_busy;
  logic [15:0]   o_pkt_count;

  fifo_serializer #(.DATA_LINE_WIDTH(DW), .FLIT_WIDTH(FW), .NUM_FLITS(NF),
                    .LOG2_NUM_FLITS(LW)) dut (
    .clk(clk), .rst(rst), .i_empty_flag(i_empty_flag),
    .o_read_packet_en(o_read_packet_en), .i_read_packet(i_read_packet),
    .o_flit(o_flit), .o_flit_valid(o_flit_valid), .o_flit_last(o_flit_last),
    .i_flit_ready(i_flit_ready), .o_busy(o_busy), .o_pkt_count(o_pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] flit; logic last; } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            ren_cycs[$];
  int            done_cycs[$];
  logic [DW-1:0] pend;
  bit            have_pend = 0;
  bit            inflight = 0;
  bit            prev_ren = 0;
  bit            stalled = 0;
  logic [FW-1:0] stall_flit;
  logic          stall_last;
  logic [15:0]   model_cnt = '0;
  int            acc_in_pkt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  // One link cycle: drive inputs at negedge, compare against the model, then
  // advance the model by whatever the DUT does at the coming rising edge.
  task automatic step(input bit rdy);
    logic [63:0] r;
    @(negedge clk);
    r = {$urandom(), $urandom()};
    i_read_packet = have_pend ? pend : r[DW-1:0];
    have_pend     = 0;
    i_flit_ready  = rdy;
    i_empty_flag  = (fifo_q.size() == 0);
    #1;
    checks++;
    if (o_busy !== inflight) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, inflight);
    end
    checks++;
    if (o_pkt_count !== model_cnt) begin
      errors++; $display("FAIL pkt_count cyc=%0d got=%h exp=%h", cyc, o_pkt_count, model_cnt);
    end
    checks++;
    if (o_flit_valid) begin
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_flit cyc=%0d got=%h exp=none", cyc, o_flit);
      end else if (o_flit !== exp_q[0].flit || o_flit_last !== exp_q[0].last) begin
        errors++; $display("FAIL flit cyc=%0d got=%h/%b exp=%h/%b", cyc, o_flit, o_flit_last,
                           exp_q[0].flit, exp_q[0].last);
      end
    end else if (o_flit !== '0 || o_flit_last !== 1'b0) begin
      errors++; $display("FAIL idle_outputs cyc=%0d got=%h/%b exp=0/0", cyc, o_flit, o_flit_last);
    end
    if (stalled) begin
      checks++;
      if (o_flit_valid !== 1'b1 || o_flit !== stall_flit || o_flit_last !== stall_last) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, o_flit_valid,
                           o_flit, o_flit_last, stall_flit, stall_last);
      end
    end
    stalled    = o_flit_valid && !rdy;
    stall_flit = o_flit;
    stall_last = o_flit_last;
    if (o_flit_valid && rdy && exp_q.size() > 0) begin
      if (exp_q[0].last) begin
        model_cnt++;
        inflight   = 0;
        acc_in_pkt = 0;
        done_cycs.push_back(cyc);
      end else begin
        acc_in_pkt++;
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (o_read_packet_en && (prev_ren || i_empty_flag)) begin
      errors++; $display("FAIL read_en_rule cyc=%0d got=1 exp=0 (prev=%b empty=%b)", cyc,
                         prev_ren, i_empty_flag);
    end
    if (o_read_packet_en && fifo_q.size() > 0) begin
      pend      = fifo_q.pop_front();
      have_pend = 1;
      inflight  = 1;
      ren_cycs.push_back(cyc);
      for (int k = 0; k < NF; k++) exp_q.push_back('{pend[k*FW +: FW], (k == NF - 1)});
    end
    prev_ren = o_read_packet_en;
    cyc++;
  endtask

  task automatic run_until_drained(input int budget, input string name);
    int n = 0;
    while ((fifo_q.size() > 0 || inflight) && n < budget) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (fifo_q.size() > 0 || inflight) begin
      errors++; $display("FAIL %s_timeout got=busy exp=drained within %0d", name, budget);
    end
  endtask

  task automatic test_reset();
    fifo_q.push_back(40'h12_34_56_78_9A);
    i_empty_flag = 1'b0;
    i_flit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (o_read_packet_en !== 1'b0 || o_flit_valid !== 1'b0 || o_flit_last !== 1'b0 ||
          o_flit !== '0 || o_busy !== 1'b0 || o_pkt_count !== 16'h0) begin
        errors++; $display("FAIL reset_state got=%b%b%b_%h_%b_%h exp=000_00_0_0000",
                           o_read_packet_en, o_flit_valid, o_flit_last, o_flit, o_busy, o_pkt_count);
      end
    end
    fifo_q.delete();
    i_empty_flag = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    ren_cycs.delete(); done_cycs.delete();
    fifo_q.push_back(40'h55_44_33_22_11);
    run_until_drained(30, "single");
    step(1'b1);
    checks++;
    if (ren_cycs.size() != 1 || done_cycs.size() != 1) begin
      errors++; $display("FAIL single_counts got=%0d/%0d exp=1/1", ren_cycs.size(), done_cycs.size());
    end else if (done_cycs[0] - ren_cycs[0] != NF + 1) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", done_cycs[0] - ren_cycs[0], NF + 1);
    end
    checks++;
    if (o_pkt_count !== 16'd1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL single_end got=%h/%b exp=0001/0", o_pkt_count, o_busy);
    end
  endtask

  task automatic test_backpressure();
    int stall_left = 3;
    int n = 0;
    ren_cycs.delete(); done_cycs.delete();
    fifo_q.push_back(40'h55_44_33_22_11);
    while ((fifo_q.size() > 0 || inflight) && n < 40) begin
      if (inflight && acc_in_pkt == 2 && exp_q.size() == 3 && stall_left > 0 &&
          ren_cycs.size() == 1 && cyc >= ren_cycs[0] + 2) begin
        stall_left--;
        step(1'b0);
      end else begin
        step(1'b1);
      end
      n++;
    end
    checks++;
    if (done_cycs.size() != 1 || ren_cycs.size() != 1) begin
      errors++; $display("FAIL bp_counts got=%0d/%0d exp=1/1", ren_cycs.size(), done_cycs.size());
    end else if (done_cycs[0] - ren_cycs[0] != NF + 1 + 3) begin
      errors++; $display("FAIL bp_latency got=%0d exp=%0d", done_cycs[0] - ren_cycs[0], NF + 4);
    end
  endtask

  task automatic test_back_to_back();
    ren_cycs.delete(); done_cycs.delete();
    fifo_q.push_back(40'hA5_00_FF_01_80);
    fifo_q.push_back(40'h0);
    run_until_drained(40, "b2b");
    checks++;
    if (ren_cycs.size() != 2 || done_cycs.size() != 2) begin
      errors++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", ren_cycs.size(), done_cycs.size());
    end else begin
      if (ren_cycs[1] != done_cycs[0]) begin
        errors++; $display("FAIL b2b_overlap got=%0d exp=%0d", ren_cycs[1], done_cycs[0]);
      end
      checks++;
      if (done_cycs[1] - ren_cycs[0] != 2 * (NF + 1)) begin
        errors++; $display("FAIL b2b_span got=%0d exp=%0d", done_cycs[1] - ren_cycs[0], 2 * (NF + 1));
      end
    end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 20; i++) begin
      step(i[0]);
      checks++;
      if (o_read_packet_en !== 1'b0 || o_flit_valid !== 1'b0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL empty got=%b%b%b exp=000", o_read_packet_en, o_flit_valid, o_busy);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    int n = 0;
    int sent = 0;
    while (sent < 30 && n < 800) begin
      if ($urandom_range(0, 3) == 0) begin
        r = {$urandom(), $urandom()};
        fifo_q.push_back(($urandom_range(0, 7) == 0) ? '0 : r[DW-1:0]);
        sent++;
      end
      step($urandom_range(0, 3) != 0);
      n++;
    end
    run_until_drained(400, "random");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fifo_q.push_back(40'hEE_DD_CC_BB_AA);
    while (acc_in_pkt == 0 && n < 20) begin
      step(1'b1);
      n++;
    end
    @(posedge clk);
    #2;
    fifo_q.push_back(40'h99_88_77_66_55);
    i_empty_flag = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (o_read_packet_en !== 1'b0 || o_flit_valid !== 1'b0 || o_flit_last !== 1'b0 ||
        o_flit !== '0 || o_busy !== 1'b0 || o_pkt_count !== 16'h0) begin
      errors++; $display("FAIL reset_mid got=%b%b%b_%h_%b_%h exp=000_00_0_0000",
                         o_read_packet_en, o_flit_valid, o_flit_last, o_flit, o_busy, o_pkt_count);
    end
    @(negedge clk);
    fifo_q.delete();
    exp_q.delete();
    i_empty_flag = 1'b1;
    have_pend = 0; inflight = 0; prev_ren = 0; stalled = 0;
    acc_in_pkt = 0; model_cnt = '0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_count_q;
    model_cnt = 16'hFFFF;
    fifo_q.push_back(40'h01_02_03_04_05);
    run_until_drained(30, "wrap");
    step(1'b1);
    checks++;
    if (o_pkt_count !== 16'h0000) begin
      errors++; $display("FAIL wrap got=%h exp=0000", o_pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_empty();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
